hilo_writeback_pipe: RTL
========================

Name: hilo_writeback_pipe

Overview:
- Receiving end of the EX-stage HI/LO write interface (`ex_hi_i`, `ex_lo_i`, `ex_whilo_i`).
- Carries HI/LO write requests through the EX/MEM and MEM/WB pipeline registers, with stall, bubble and flush control.
- Commits them into the architectural HI/LO register pair.
- Returns three things to EX: the committed HI/LO values, plus the MEM-stage and WB-stage bypass triples that EX uses for forwarding.

Parameters:
- DATA_W, 32, width of the HI and LO words.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high
- ex_hi_i  in  DATA_W  HI value produced by EX
- ex_lo_i  in  DATA_W  LO value produced by EX
- ex_whilo_i  in  1  EX requests a HI/LO write
- stall_ex  in  1  EX stage stalled this cycle
- stall_mem  in  1  MEM stage stalled this cycle
- stall_wb  in  1  WB stage stalled this cycle
- flush  in  1  discard all in-flight HI/LO writes
- mem_hi_o  out  DATA_W  EX/MEM register HI (bypass to EX)
- mem_lo_o  out  DATA_W  EX/MEM register LO (bypass to EX)
- mem_whilo_o  out  1  EX/MEM register write-enable (bypass to EX)
- wb_hi_o  out  DATA_W  MEM/WB register HI (bypass to EX)
- wb_lo_o  out  DATA_W  MEM/WB register LO (bypass to EX)
- wb_whilo_o  out  1  MEM/WB register write-enable (bypass to EX)
- hi_o  out  DATA_W  architectural HI
- lo_o  out  DATA_W  architectural LO
- commit_cnt_o  out  16  number of HI/LO commits since reset

Behaviour:
- All outputs are registered. There is no combinational path from any input to any output.
- Reset (rst=1 at a rising edge) clears every register to 0: both pipe stages, HI, LO, commit_cnt_o. Reset has priority over flush and stall, and aborts any in-flight write.
- EX/MEM stage register {mem_hi_o, mem_lo_o, mem_whilo_o}, evaluated each edge in priority order:
  - flush=1: clear all fields to 0.
  - stall_ex=1 and stall_mem=0: insert a bubble (all fields cleared to 0).
  - stall_ex=0: load {ex_hi_i, ex_lo_i, ex_whilo_i}.
  - otherwise: hold.
- MEM/WB stage register {wb_hi_o, wb_lo_o, wb_whilo_o}: same rule set, applied with stall_mem/stall_wb in place of stall_ex/stall_mem, and with the EX/MEM register as its source.
- Commit: at an edge where rst=0 and wb_whilo_o=1, HI<=wb_hi_o and LO<=wb_lo_o, and commit_cnt_o increments.
  - commit_cnt_o wraps from 0xFFFF to 0.
  - A held (stalled) MEM/WB entry recommits the same value every cycle. This is harmless to HI/LO but does increment the counter.
- flush does not gate the commit occurring at the same edge. The WB entry already present commits, and both stage registers are then cleared.
- Latency: an ex_whilo_i=1 sampled at edge N appears in mem_* after edge N, in wb_* after edge N+1, and in hi_o/lo_o after edge N+2 (no stalls).
- Back-to-back writes on consecutive cycles commit in order, one per cycle. The last one wins.
- Write enable is a single bit covering both halves. MTHI/MTLO semantics (one half unchanged) are the producer's responsibility; this block writes both halves verbatim.
- A bubble or flush clears data as well as enable, so bypass outputs read 0 when invalid.
- Stall combinations with stall_mem=1 and stall_ex=0 are illegal from the controller. If they occur, the EX/MEM register loads (the upstream entry is lost); no assertion is required in RTL.

Test Plan:
- Reset: after rst=1 for 2 cycles, all outputs 0; hold rst=1 with ex_whilo_i=1, ex_hi_i=0x1234 → outputs stay 0.
- Basic write: ex_whilo_i=1, hi=0xAAAA0001, lo=0x5555_0002 for one cycle → mem_* after 1 edge, wb_* after 2, hi_o/lo_o after 3; commit_cnt_o=1.
- Back-to-back: writes (1,2),(3,4),(5,6) on consecutive cycles → hi_o/lo_o step 1/2, 3/4, 5/6 on successive cycles; commit_cnt_o=3.
- Stall bubble: stall_ex=1, stall_mem=0 for 2 cycles with ex_whilo_i=1, hi=0x77 → mem_whilo_o=0 and mem_hi_o=0 during the stall; after stall release, value 0x77 propagates normally.
- Flush: write 0x11 at cycle N, flush=1 at cycle N+1 → the entry is discarded, hi_o stays at its prior value, mem_*/wb_* read 0 the next cycle.
- Flush with WB valid: wb_whilo_o=1, wb_hi_o=0x99 and flush=1 at the same edge → hi_o=0x99 and commit_cnt_o increments; both stage registers cleared.

Source files
------------

// File: rtl/hilo_writeback_pipe.sv
// rtl/hilo_writeback_pipe.sv - HI/LO write pipeline (EX/MEM, MEM/WB) with commit into architectural HI/LO
module hilo_writeback_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_hi_i,
  input  logic [DATA_W-1:0] ex_lo_i,
  input  logic              ex_whilo_i,
  input  logic              stall_ex,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  output logic [DATA_W-1:0] mem_hi_o,
  output logic [DATA_W-1:0] mem_lo_o,
  output logic              mem_whilo_o,
  output logic [DATA_W-1:0] wb_hi_o,
  output logic [DATA_W-1:0] wb_lo_o,
  output logic              wb_whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [15:0]       commit_cnt_o
);

  logic clear_mem;
  logic load_mem;
  logic clear_wb;
  logic load_wb;

  // A stage clears on flush or when its producer stalls while it is free to drain (bubble);
  // it loads whenever its producer advances, otherwise it holds.
  always_comb begin
    clear_mem = flush | (stall_ex & ~stall_mem);
    load_mem  = ~stall_ex;
    clear_wb  = flush | (stall_mem & ~stall_wb);
    load_wb   = ~stall_mem;
  end

  // EX/MEM pipeline register, doubles as the MEM-stage bypass to EX
  always_ff @(posedge clk) begin
    if (rst || clear_mem) begin
      mem_hi_o    <= '0;
      mem_lo_o    <= '0;
      mem_whilo_o <= 1'b0;
    end else if (load_mem) begin
      mem_hi_o    <= ex_hi_i;
      mem_lo_o    <= ex_lo_i;
      mem_whilo_o <= ex_whilo_i;
    end
  end

  // MEM/WB pipeline register, doubles as the WB-stage bypass to EX
  always_ff @(posedge clk) begin
    if (rst || clear_wb) begin
      wb_hi_o    <= '0;
      wb_lo_o    <= '0;
      wb_whilo_o <= 1'b0;
    end else if (load_wb) begin
      wb_hi_o    <= mem_hi_o;
      wb_lo_o    <= mem_lo_o;
      wb_whilo_o <= mem_whilo_o;
    end
  end

  // Architectural HI/LO commit; a held WB entry recommits (and counts) every cycle,
  // and a same-edge flush does not suppress the commit of the entry already in WB
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o         <= '0;
      lo_o         <= '0;
      commit_cnt_o <= '0;
    end else if (wb_whilo_o) begin
      hi_o         <= wb_hi_o;
      lo_o         <= wb_lo_o;
      commit_cnt_o <= commit_cnt_o + 16'd1;
    end
  end

endmodule
